alu_result_queue: RTL and testbench

ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

---
 rtl/alu_result_queue.sv | 99 +++++++++
 tb/tb_alu_result_queue.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_queue.sv
// alu_result_queue: first-word-fall-through circular queue of ALU results.
// Zero/negative flags are computed on entry; a free-running push counter survives flush.
module alu_result_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              result,
   input  logic [2:0]               operation,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_result,
   output logic [2:0]               out_operation,
   output logic                     out_zero,
   output logic                     out_negative,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              accepted
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] res;
      logic        zero;
      logic        neg;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] cnt;
   logic [15:0]   acc;
   logic          push;
   logic          pop;
   entry_t        head;

   assign in_ready  = (cnt < CW'(DEPTH));
   assign out_valid = (cnt != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign head      = mem[rptr];
   assign count     = cnt;
   assign accepted  = acc;

   // Storage write; contents are don't-care until written, so no reset
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wptr] <= '{op: operation, res: result,
                        zero: (result == 32'd0), neg: result[31]};
      end
   end

   // Pointers and occupancy; flush overrides any same-cycle push or pop
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
         if (pop)  rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
         unique case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Lifetime push counter, wraps naturally, untouched by flush
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) acc <= '0;
      else if (push) acc <= acc + 16'd1;
   end

   // Head presentation, forced to zero while the queue is empty
   always_comb begin
      out_result    = '0;
      out_operation = '0;
      out_zero      = 1'b0;
      out_negative  = 1'b0;
      if (out_valid) begin
         out_result    = head.res;
         out_operation = head.op;
         out_zero      = head.zero;
         out_negative  = head.neg;
      end
   end

endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_alu_result_queue;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] result = '0;
   logic [2:0]  operation = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic [2:0]  out_operation;
   logic        out_zero;
   logic        out_negative;
   logic [2:0]  count;
   logic [15:0] accepted;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [34:0] mq[$];
   logic [15:0] acc_m = '0;

   alu_result_queue #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .result(result), .operation(operation),
      .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result),
      .out_operation(out_operation), .out_zero(out_zero),
      .out_negative(out_negative), .count(count),
      .accepted(accepted)
   );

   always #5 clock = ~clock;

   // One clock edge; the reference queue follows the handshake rules
   task automatic tick();
      bit p, q;
      p = reset_n && in_valid && mq.size() < DEPTH && !flush;
      q = reset_n && out_ready && mq.size() > 0 && !flush;
      @(posedge clock);
      if (reset_n) begin
         if (flush) mq.delete();
         else begin
            if (q) void'(mq.pop_front());
            if (p) mq.push_back({operation, result});
         end
         if (p) acc_m = acc_m + 16'd1;
      end
      #1;
   endtask

   task automatic idle();
      in_valid = 0; out_ready = 0; flush = 0;
      result = '0; operation = '0;
   endtask

   task automatic do_reset();
      idle();
      reset_n = 0;
      mq.delete();
      acc_m = '0;
      tick();
      tick();
      reset_n = 1;
   endtask

   task automatic push_n(input int n, input logic [31:0] base);
      out_ready = 0;
      for (int i = 0; i < n; i++) begin
         in_valid = 1; result = base + 32'(i); operation = 3'(i);
         tick();
      end
      in_valid = 0;
   endtask

   task automatic test_reset();
      idle();
      reset_n = 0;
      #3;
      n_checks++;
      if ({out_valid, count, in_ready, accepted, out_result} !==
          {1'b0, 3'd0, 1'b1, 16'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL reset: valid=%b cnt=%0d rdy=%b acc=%0d res=%h",
                  out_valid, count, in_ready, accepted, out_result);
      end
      do_reset();
   endtask

   task automatic test_single();
      in_valid = 1; result = 32'h5; operation = 3'b011; out_ready = 1;
      tick();
      in_valid = 0;
      n_checks++;
      if ({out_valid, out_result, out_operation, out_zero, out_negative, count} !==
          {1'b1, 32'h5, 3'b011, 1'b0, 1'b0, 3'd1}) begin
         n_fail++;
         $display("FAIL single_head: v=%b res=%h op=%b z=%b n=%b cnt=%0d, need 1 5 011 0 0 1",
                  out_valid, out_result, out_operation, out_zero, out_negative, count);
      end
      tick();
      n_checks++;
      if ({count, out_valid} !== {3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL single_pop: cnt=%0d v=%b, need 0 0", count, out_valid);
      end
      idle();
   endtask

   task automatic test_fill();
      do_reset();
      out_ready = 0;
      for (int i = 1; i <= 5; i++) begin
         in_valid = 1; result = 32'(i); operation = 3'(i);
         tick();
         if (i == 4) begin
            n_checks++;
            if ({in_ready, count} !== {1'b0, 3'd4}) begin
               n_fail++;
               $display("FAIL fill_full: rdy=%b cnt=%0d, need 0 4", in_ready, count);
            end
         end
      end
      in_valid = 0;
      n_checks++;
      if ({count, accepted} !== {3'd4, 16'd4}) begin
         n_fail++;
         $display("FAIL fill_fifth: cnt=%0d acc=%0d, need 4 4", count, accepted);
      end
      out_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         n_checks++;
         if ({out_valid, out_result} !== {1'b1, 32'(i)}) begin
            n_fail++;
            $display("FAIL drain_%0d: v=%b res=%h, need 1 %h", i, out_valid, out_result, 32'(i));
         end
         tick();
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty: v=%b, need 0", out_valid);
      end
      idle();
   endtask

   task automatic test_full_simul();
      do_reset();
      push_n(4, 32'h11);
      in_valid = 1; result = 32'hAA; operation = 3'b110; out_ready = 1;
      tick();
      n_checks++;
      if ({count, in_ready, accepted} !== {3'd3, 1'b1, 16'd4}) begin
         n_fail++;
         $display("FAIL full_simul: cnt=%0d rdy=%b acc=%0d, need 3 1 4", count, in_ready, accepted);
      end
      out_ready = 0;
      tick();
      n_checks++;
      if ({count, accepted} !== {3'd4, 16'd5}) begin
         n_fail++;
         $display("FAIL full_retry: cnt=%0d acc=%0d, need 4 5", count, accepted);
      end
      idle();
   endtask

   task automatic test_flags();
      do_reset();
      out_ready = 0;
      in_valid = 1; result = 32'h0; tick();
      result = 32'h8000_0000; tick();
      in_valid = 0;
      n_checks++;
      if ({out_zero, out_negative} !== 2'b10) begin
         n_fail++;
         $display("FAIL flags_zero: z=%b n=%b, need 1 0", out_zero, out_negative);
      end
      out_ready = 1;
      tick();
      n_checks++;
      if ({out_zero, out_negative, out_result} !== {2'b01, 32'h8000_0000}) begin
         n_fail++;
         $display("FAIL flags_neg: z=%b n=%b res=%h, need 0 1 80000000",
                  out_zero, out_negative, out_result);
      end
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      push_n(3, 32'h100);
      flush = 1; in_valid = 1; out_ready = 1; result = 32'h77;
      tick();
      idle();
      n_checks++;
      if ({count, out_valid, out_result, accepted} !== {3'd0, 1'b0, 32'd0, 16'd3}) begin
         n_fail++;
         $display("FAIL flush: cnt=%0d v=%b res=%h acc=%0d, need 0 0 0 3",
                  count, out_valid, out_result, accepted);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      push_n(2, 32'h200);
      #3;
      reset_n = 0;
      #1;
      n_checks++;
      if ({out_valid, count, accepted, in_ready} !== {1'b0, 3'd0, 16'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL async_reset: v=%b cnt=%0d acc=%0d rdy=%b, need 0 0 0 1",
                  out_valid, count, accepted, in_ready);
      end
      mq.delete();
      acc_m = '0;
      tick();
      reset_n = 1;
      out_ready = 1;
      tick();
      tick();
      n_checks++;
      if ({out_valid, count} !== {1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL reset_discard: v=%b cnt=%0d, need 0 0", out_valid, count);
      end
      idle();
   endtask

   task automatic test_random();
      logic [57:0] exp_v;
      logic [57:0] got_v;
      logic [34:0] h;
      int          rdy_pct;
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         rdy_pct = ((c / 500) % 2 == 0) ? 30 : 80;
         in_valid  = ($urandom_range(99) < 70);
         out_ready = ($urandom_range(99) < rdy_pct);
         flush     = ($urandom_range(99) < 2);
         operation = 3'($urandom_range(6));
         case ($urandom_range(3))
            0: result = 32'd0;
            1: result = 32'h8000_0000 | $urandom;
            default: result = $urandom;
         endcase
         tick();
         h = (mq.size() > 0) ? mq[0] : '0;
         exp_v = {mq.size() > 0, h[31:0], h[34:32],
                  mq.size() > 0 && h[31:0] == 32'd0,
                  mq.size() > 0 && h[31],
                  3'(mq.size()), mq.size() < DEPTH, acc_m};
         got_v = {out_valid, out_result, out_operation, out_zero,
                  out_negative, count, in_ready, accepted};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL random_c%0d: got=%h need=%h", c, got_v, exp_v);
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_full_simul();
      test_flags();
      test_flush();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
